// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the hazard /
// flow controller (slave).
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_useRs1;
  logic             id_useRs2;
  logic [4:0]       id_rd;
  logic             id_regWrite;
  logic             ex_branchTaken;
  logic             imem_ready;
  logic             pc_en;
  logic             freeze_o;
  logic             hold_o;
  logic             ex_bubble_o;
  logic [1:0]       fwdA_o;
  logic [1:0]       fwdB_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_rs1, id_rs2, id_useRs1, id_useRs2, id_rd, id_regWrite,
           ex_branchTaken, imem_ready,
    input  pc_en, freeze_o, hold_o, ex_bubble_o, fwdA_o, fwdB_o, stall_cnt_o
  );

  modport slave (
    input  id_rs1, id_rs2, id_useRs1, id_useRs2, id_rd, id_regWrite,
           ex_branchTaken, imem_ready,
    output pc_en, freeze_o, hold_o, ex_bubble_o, fwdA_o, fwdB_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline flow controller: branch flush, RAW hazard handling (forwarding or
// interlock), instruction-fetch wait, and a saturating stall counter.
module pipe_ctrl #(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave ctrl
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, WAIT = 2'd2} state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
  } wrEntry_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
  } rdEntry_t;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_t           state, stateNext;
  wrEntry_t         exWr, memWr, wbWr;
  rdEntry_t         exRd;
  logic             pcEn, freeze, hold, exBubble;
  logic [1:0]       fwdA, fwdB;
  logic             decodeHit;
  logic [CNT_W-1:0] stallCnt;

  // A writer feeds a reader only for a real write to a non-zero register.
  function automatic logic srcHit(wrEntry_t w, logic [4:0] rs, logic useSrc);
    return useSrc && w.we && (w.rd != 5'd0) && (w.rd == rs);
  endfunction

  // MEM is the younger result, so it wins over WB.
  function automatic logic [1:0] fwdSel(logic [4:0] rs, logic useSrc,
                                        wrEntry_t m, wrEntry_t w);
    if (srcHit(m, rs, useSrc)) return 2'b01;
    if (srcHit(w, rs, useSrc)) return 2'b10;
    return 2'b00;
  endfunction

  assign decodeHit =
      srcHit(exWr,  ctrl.id_rs1, ctrl.id_useRs1) | srcHit(exWr,  ctrl.id_rs2, ctrl.id_useRs2) |
      srcHit(memWr, ctrl.id_rs1, ctrl.id_useRs1) | srcHit(memWr, ctrl.id_rs2, ctrl.id_useRs2) |
      srcHit(wbWr,  ctrl.id_rs1, ctrl.id_useRs1) | srcHit(wbWr,  ctrl.id_rs2, ctrl.id_useRs2);

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= RUN;
    else     state <= stateNext;
  end

  // Next-state and pipeline control outputs; reset forces a safe bubble.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    stateNext = state;
    pcEn      = 1'b1;
    freeze    = 1'b0;
    hold      = 1'b0;
    exBubble  = 1'b0;
    if (rst) begin
      stateNext = RUN;
      pcEn      = 1'b0;
      freeze    = 1'b1;
      exBubble  = 1'b1;
    end else begin
      case (state)
        FLUSH: begin
          // EX holds the squashed slot, so a branch signal here is stale.
          freeze    = 1'b1;
          pcEn      = ctrl.imem_ready;
          stateNext = ctrl.imem_ready ? RUN : WAIT;
        end
        WAIT: begin
          if (ctrl.ex_branchTaken) begin
            freeze    = 1'b1;
            exBubble  = 1'b1;
            stateNext = FLUSH;
          end else begin
            pcEn   = ctrl.imem_ready;
            freeze = ~ctrl.imem_ready;
            if (ctrl.imem_ready) stateNext = RUN;
          end
        end
        default: begin
          if (ctrl.ex_branchTaken) begin
            freeze    = 1'b1;
            exBubble  = 1'b1;
            stateNext = FLUSH;
          end else if (!FWD_EN && decodeHit) begin
            pcEn     = 1'b0;
            hold     = 1'b1;
            exBubble = 1'b1;
          end else if (!ctrl.imem_ready) begin
            pcEn      = 1'b0;
            freeze    = 1'b1;
            stateNext = WAIT;
          end
        end
      endcase
    end
  end

  // Scoreboard shift: WB <- MEM <- EX <- decode (or a bubble).
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the we/use qualifiers are cleared; register indices are
      // don't-care while their qualifier is 0, so they need no reset.
      exWr.we   <= 1'b0;
      memWr.we  <= 1'b0;
      wbWr.we   <= 1'b0;
      exRd.use1 <= 1'b0;
      exRd.use2 <= 1'b0;
    end else begin
      wbWr  <= memWr;
      memWr <= exWr;
      if (exBubble) begin
        exWr.we   <= 1'b0;
        exRd.use1 <= 1'b0;
        exRd.use2 <= 1'b0;
      end else begin
        exWr <= '{rd: ctrl.id_rd, we: ctrl.id_regWrite};
        exRd <= '{rs1: ctrl.id_rs1, rs2: ctrl.id_rs2,
                  use1: ctrl.id_useRs1, use2: ctrl.id_useRs2};
      end
    end
  end

  // Operand-source selection for the instruction currently in EX.
  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (FWD_EN && !rst) begin
      fwdA = fwdSel(exRd.rs1, exRd.use1, memWr, wbWr);
      fwdB = fwdSel(exRd.rs2, exRd.use2, memWr, wbWr);
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk) begin
    if (rst)                           stallCnt <= '0;
    else if (!pcEn && stallCnt != CntMax) stallCnt <= stallCnt + CntOne;
  end

  assign ctrl.pc_en       = pcEn;
  assign ctrl.freeze_o    = freeze;
  assign ctrl.hold_o      = hold;
  assign ctrl.ex_bubble_o = exBubble;
  assign ctrl.fwdA_o      = fwdA;
  assign ctrl.fwdB_o      = fwdB;
  assign ctrl.stall_cnt_o = stallCnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: three configurations share one stimulus stream
// (forwarding, interlock, 2-bit counter); a pipeline-history model checks
// every cycle and directed scenarios pin literal expectations.
module tb_pipe_ctrl;
  typedef struct {
    bit [4:0] rd, rs1, rs2;
    bit       we, u1, u2;
  } instr_t;

  typedef struct {
    logic        pc, fr, ho, bub;
    logic [1:0]  fa, fb;
    logic [31:0] cnt;
  } outs_t;

  localparam bit FWD_CFG [3] = '{1'b1, 1'b0, 1'b1};
  localparam int CNT_MAX [3] = '{65535, 65535, 3};

  logic   clk = 1'b0;
  bit     rst, br, rdy;
  instr_t dec;
  int     total, bad;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(16)) if_fwd ();
  pipe_ctrl_if #(.CNT_W(16)) if_stl ();
  pipe_ctrl_if #(.CNT_W(2))  if_sat ();

  pipe_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) u_fwd (.clk(clk), .rst(rst), .ctrl(if_fwd));
  pipe_ctrl #(.FWD_EN(1'b0), .CNT_W(16)) u_stl (.clk(clk), .rst(rst), .ctrl(if_stl));
  pipe_ctrl #(.FWD_EN(1'b1), .CNT_W(2))  u_sat (.clk(clk), .rst(rst), .ctrl(if_sat));

  assign if_fwd.id_rs1 = dec.rs1; assign if_fwd.id_rs2 = dec.rs2; assign if_fwd.id_rd = dec.rd;
  assign if_fwd.id_useRs1 = dec.u1; assign if_fwd.id_useRs2 = dec.u2; assign if_fwd.id_regWrite = dec.we;
  assign if_fwd.ex_branchTaken = br; assign if_fwd.imem_ready = rdy;
  assign if_stl.id_rs1 = dec.rs1; assign if_stl.id_rs2 = dec.rs2; assign if_stl.id_rd = dec.rd;
  assign if_stl.id_useRs1 = dec.u1; assign if_stl.id_useRs2 = dec.u2; assign if_stl.id_regWrite = dec.we;
  assign if_stl.ex_branchTaken = br; assign if_stl.imem_ready = rdy;
  assign if_sat.id_rs1 = dec.rs1; assign if_sat.id_rs2 = dec.rs2; assign if_sat.id_rd = dec.rd;
  assign if_sat.id_useRs1 = dec.u1; assign if_sat.id_useRs2 = dec.u2; assign if_sat.id_regWrite = dec.we;
  assign if_sat.ex_branchTaken = br; assign if_sat.imem_ready = rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic instr_t mk(input bit [4:0] rd, rs1, rs2, input bit we, u1, u2);
    instr_t r;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.we = we; r.u1 = u1; r.u2 = u2;
    return r;
  endfunction

  function automatic string nm(input int i);
    case (i)
      0:       return "fwd";
      1:       return "stl";
      default: return "sat";
    endcase
  endfunction

  function automatic outs_t actual(input int i);
    outs_t o;
    case (i)
      0: begin
        o.pc = if_fwd.pc_en; o.fr = if_fwd.freeze_o; o.ho = if_fwd.hold_o; o.bub = if_fwd.ex_bubble_o;
        o.fa = if_fwd.fwdA_o; o.fb = if_fwd.fwdB_o; o.cnt = 32'(if_fwd.stall_cnt_o);
      end
      1: begin
        o.pc = if_stl.pc_en; o.fr = if_stl.freeze_o; o.ho = if_stl.hold_o; o.bub = if_stl.ex_bubble_o;
        o.fa = if_stl.fwdA_o; o.fb = if_stl.fwdB_o; o.cnt = 32'(if_stl.stall_cnt_o);
      end
      default: begin
        o.pc = if_sat.pc_en; o.fr = if_sat.freeze_o; o.ho = if_sat.hold_o; o.bub = if_sat.ex_bubble_o;
        o.fa = if_sat.fwdA_o; o.fb = if_sat.fwdB_o; o.cnt = 32'(if_sat.stall_cnt_o);
      end
    endcase
    return o;
  endfunction

  // ---------------- behavioural model ----------------
  // hist[i][0] is the instruction in EX, [1] in MEM, [2] in WB.
  instr_t hist [3][3];
  bit     squashPending [3];  // previous cycle redirected the PC
  bit     fetchPending  [3];  // previous cycle froze decode without advancing
  int     stalls        [3];

  function automatic bit feeds(input instr_t w, input bit [4:0] rs, input bit u);
    return u && w.we && (w.rd != 0) && (w.rd == rs);
  endfunction

  function automatic logic [1:0] source(input instr_t ex, input bit b, input instr_t mem, input instr_t wb);
    bit [4:0] rs;
    bit u;
    rs = b ? ex.rs2 : ex.rs1;
    u  = b ? ex.u2  : ex.u1;
    if (feeds(mem, rs, u)) return 2'd1;
    if (feeds(wb,  rs, u)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_cycle(input int i);
    outs_t  a, e;
    bit     redirect, raw;
    instr_t nop;
    nop = mk(0, 0, 0, 0, 0, 0);
    a = actual(i);
    e.pc = 1; e.fr = 0; e.ho = 0; e.bub = 0; e.fa = 0; e.fb = 0; e.cnt = stalls[i];
    redirect = 0;
    raw = 0;
    if (rst) begin
      e.pc = 0; e.fr = 1; e.bub = 1;
    end else begin
      redirect = br && !squashPending[i];
      if (!FWD_CFG[i])
        for (int k = 0; k < 3; k++)
          raw |= feeds(hist[i][k], dec.rs1, dec.u1) | feeds(hist[i][k], dec.rs2, dec.u2);
      if (redirect)              begin e.fr = 1; e.bub = 1; end
      else if (squashPending[i]) begin e.fr = 1; e.pc = rdy; end
      else if (fetchPending[i])  begin e.pc = rdy; e.fr = !rdy; end
      else if (raw)              begin e.pc = 0; e.ho = 1; e.bub = 1; end
      else if (!rdy)             begin e.pc = 0; e.fr = 1; end
      if (FWD_CFG[i]) begin
        e.fa = source(hist[i][0], 1'b0, hist[i][1], hist[i][2]);
        e.fb = source(hist[i][0], 1'b1, hist[i][1], hist[i][2]);
      end
    end
    check({nm(i), ".pc_en"},     a.pc,  e.pc);
    check({nm(i), ".freeze"},    a.fr,  e.fr);
    check({nm(i), ".hold"},      a.ho,  e.ho);
    check({nm(i), ".bubble"},    a.bub, e.bub);
    check({nm(i), ".fwdA"},      a.fa,  e.fa);
    check({nm(i), ".fwdB"},      a.fb,  e.fb);
    check({nm(i), ".stall_cnt"}, a.cnt, e.cnt);
    check({nm(i), ".hold&freeze"}, a.ho & a.fr, 1'b0);
    if (rst) begin
      for (int k = 0; k < 3; k++) hist[i][k] = nop;
      squashPending[i] = 0;
      fetchPending[i]  = 0;
      stalls[i]        = 0;
    end else begin
      if (!e.pc && stalls[i] < CNT_MAX[i]) stalls[i]++;
      fetchPending[i]  = !redirect && !e.pc && e.fr;
      squashPending[i] = redirect;
      hist[i][2] = hist[i][1];
      hist[i][1] = hist[i][0];
      hist[i][0] = e.bub ? nop : dec;
    end
  endtask

  // Compare process: every negedge once the first reset edge has happened.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) model_cycle(i);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input bit r, input bit b, input bit ready, input instr_t d);
    @(posedge clk);
    #1;
    rst = r; br = b; rdy = ready; dec = d;
    @(negedge clk);
  endtask

  initial begin
    instr_t NOP, I1, I2, I3;
    NOP = mk(0, 0, 0, 0, 0, 0);
    I1  = mk(5, 1, 2, 1, 1, 1);   // add x5, x1, x2
    I2  = mk(6, 5, 5, 1, 1, 1);   // add x6, x5, x5
    I3  = mk(7, 1, 2, 1, 1, 1);   // independent
    total = 0; bad = 0;
    rst = 1; br = 0; rdy = 1; dec = NOP;

    // Reset state
    cyc(1, 0, 1, NOP); cyc(1, 0, 1, NOP);
    check("rst.pc_en", if_fwd.pc_en, 1'b0);
    check("rst.freeze", if_fwd.freeze_o, 1'b1);
    check("rst.hold", if_fwd.hold_o, 1'b0);
    check("rst.bubble", if_fwd.ex_bubble_o, 1'b1);
    check("rst.cnt", if_fwd.stall_cnt_o, 16'd0);

    // Forwarding: MEM result, then independent, then WB result, then MEM over WB
    cyc(0, 0, 1, I1); cyc(0, 0, 1, I2); cyc(0, 0, 1, I3);
    check("fwd.mem.A", if_fwd.fwdA_o, 2'b01);
    check("fwd.mem.B", if_fwd.fwdB_o, 2'b01);
    check("fwd.mem.pc", if_fwd.pc_en, 1'b1);
    cyc(0, 0, 1, NOP);
    check("fwd.indep.A", if_fwd.fwdA_o, 2'b00);
    check("fwd.indep.B", if_fwd.fwdB_o, 2'b00);
    check("fwd.indep.pc", if_fwd.pc_en, 1'b1);
    cyc(0, 0, 1, I1); cyc(0, 0, 1, NOP); cyc(0, 0, 1, mk(9, 5, 3, 1, 1, 1)); cyc(0, 0, 1, NOP);
    check("fwd.wb.A", if_fwd.fwdA_o, 2'b10);
    check("fwd.wb.B", if_fwd.fwdB_o, 2'b00);
    cyc(0, 0, 1, I1); cyc(0, 0, 1, mk(5, 3, 4, 1, 1, 1)); cyc(0, 0, 1, mk(10, 5, 5, 1, 1, 1));
    cyc(0, 0, 1, NOP);
    check("fwd.prio.A", if_fwd.fwdA_o, 2'b01);
    check("fwd.prio.B", if_fwd.fwdB_o, 2'b01);

    // Interlock: three stall cycles, then advance
    cyc(1, 0, 1, NOP);
    cyc(0, 0, 1, I1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, I2);
      check("stl.pc_en", if_stl.pc_en, 1'b0);
      check("stl.hold", if_stl.hold_o, 1'b1);
      check("stl.bubble", if_stl.ex_bubble_o, 1'b1);
    end
    cyc(0, 0, 1, I2);
    check("stl.adv.pc", if_stl.pc_en, 1'b1);
    check("stl.adv.hold", if_stl.hold_o, 1'b0);
    cyc(0, 0, 1, NOP);
    check("stl.cnt", if_stl.stall_cnt_o, 16'd3);
    check("stl.fwdcfg.cnt", if_fwd.stall_cnt_o, 16'd0);

    // Branch flush, branch ignored in FLUSH, FLUSH->WAIT, branch in WAIT
    cyc(1, 0, 1, NOP);
    cyc(0, 1, 1, NOP);
    check("br.freeze", if_fwd.freeze_o, 1'b1);
    check("br.bubble", if_fwd.ex_bubble_o, 1'b1);
    check("br.pc", if_fwd.pc_en, 1'b1);
    cyc(0, 0, 1, NOP);
    check("flush.freeze", if_fwd.freeze_o, 1'b1);
    check("flush.bubble", if_fwd.ex_bubble_o, 1'b0);
    cyc(0, 0, 1, NOP);
    check("flush.run", if_fwd.freeze_o, 1'b0);
    check("flush.cnt", if_fwd.stall_cnt_o, 16'd0);
    cyc(0, 1, 1, NOP); cyc(0, 1, 1, NOP);
    check("flush.ignbr", if_fwd.ex_bubble_o, 1'b0);
    cyc(0, 0, 1, NOP);
    check("flush.ignbr.run", if_fwd.freeze_o, 1'b0);
    cyc(0, 1, 1, NOP); cyc(0, 0, 0, NOP); cyc(0, 0, 0, NOP);
    check("wait.pc", if_fwd.pc_en, 1'b0);
    cyc(0, 1, 0, NOP);
    check("wait.br.pc", if_fwd.pc_en, 1'b1);
    check("wait.br.bubble", if_fwd.ex_bubble_o, 1'b1);
    cyc(0, 0, 1, NOP); cyc(0, 0, 1, NOP);
    check("wait.br.cnt", if_fwd.stall_cnt_o, 16'd2);

    // Fetch wait for 4 cycles
    cyc(1, 0, 1, NOP);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, NOP);
      check("imem.pc", if_fwd.pc_en, 1'b0);
      check("imem.freeze", if_fwd.freeze_o, 1'b1);
    end
    cyc(0, 0, 1, NOP);
    check("imem.resume.pc", if_fwd.pc_en, 1'b1);
    check("imem.resume.fr", if_fwd.freeze_o, 1'b0);
    cyc(0, 0, 1, NOP);
    check("imem.cnt", if_fwd.stall_cnt_o, 16'd4);

    // Saturation on the 2-bit counter
    cyc(1, 0, 1, NOP);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, NOP);
    cyc(0, 0, 1, NOP);
    check("sat.cnt", if_sat.stall_cnt_o, 2'd3);
    check("sat.wide.cnt", if_fwd.stall_cnt_o, 16'd6);

    // Writes to x0 neither stall nor forward
    cyc(1, 0, 1, NOP);
    cyc(0, 0, 1, mk(0, 1, 2, 1, 1, 1));
    cyc(0, 0, 1, mk(8, 0, 0, 1, 1, 1));
    check("x0.stl.pc", if_stl.pc_en, 1'b1);
    check("x0.stl.hold", if_stl.hold_o, 1'b0);
    cyc(0, 0, 1, NOP);
    check("x0.fwdA", if_fwd.fwdA_o, 2'b00);
    check("x0.fwdB", if_fwd.fwdB_o, 2'b00);

    // Reset mid-stall and mid-FLUSH
    cyc(1, 0, 1, NOP);
    cyc(0, 0, 1, I1); cyc(0, 0, 1, I2);
    check("rst.stall.hold", if_stl.hold_o, 1'b1);
    cyc(1, 0, 1, I2);
    check("rst.stall.pc", if_stl.pc_en, 1'b0);
    check("rst.stall.hold0", if_stl.hold_o, 1'b0);
    cyc(0, 0, 1, I2);
    check("rst.stall.after.pc", if_stl.pc_en, 1'b1);
    check("rst.stall.after.cnt", if_stl.stall_cnt_o, 16'd0);
    cyc(0, 1, 1, NOP); cyc(1, 0, 1, NOP); cyc(0, 0, 1, NOP);
    check("rst.flush.fr", if_fwd.freeze_o, 1'b0);
    check("rst.flush.pc", if_fwd.pc_en, 1'b1);
    check("rst.flush.cnt", if_fwd.stall_cnt_o, 16'd0);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
